// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the pipeline/IFU side and fetch_sequencer.
// With FETCH_SEQ_EXC_EN defined, adds the exception/eret request signals.
interface fetch_sequencer_if;
   logic [31:0] pc_f;
   logic [31:0] pc_d;
   logic        stall;
   logic        redir_valid;
   logic [1:0]  redir_type;
   logic [15:0] imm16;
   logic [25:0] idx26;
   logic [31:0] rs_val;
   logic [31:0] next_pc;
   logic        pc_en;
   logic        pend_valid;
   logic        misalign;
   logic [31:0] fetch_cnt;
`ifdef FETCH_SEQ_EXC_EN
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;
`endif

   // master: the pipeline/IFU side that feeds the sequencer.
   modport master (
`ifdef FETCH_SEQ_EXC_EN
      output exc_req, eret_req, epc,
`endif
      output pc_f, pc_d, stall, redir_valid, redir_type, imm16, idx26, rs_val,
      input  next_pc, pc_en, pend_valid, misalign, fetch_cnt
   );

   modport slave (
`ifdef FETCH_SEQ_EXC_EN
      input  exc_req, eret_req, epc,
`endif
      input  pc_f, pc_d, stall, redir_valid, redir_type, imm16, idx26, rs_val,
      output next_pc, pc_en, pend_valid, misalign, fetch_cnt
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: nextPC/En for the IFU, D-stage redirects, one-entry pending latch.
// Optional exception/eret entry is enabled by defining FETCH_SEQ_EXC_EN.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
   input  logic             clk,
   input  logic             reset,
   fetch_sequencer_if.slave bus
);

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] pend_tgt;
   logic [31:0] fetch_cnt_q;
   logic        misalign_q;

   logic [31:0] raw_tgt;
   logic [31:0] tgt;
   logic        redir_hit;
   logic        exc_hit;
   logic        eret_hit;
   logic [31:0] eret_tgt;
   logic [31:0] npc;
   logic        en;

   // redir_valid has no ready: stall is the only backpressure, so a redirect
   // offered during a stall is latched into pend_tgt instead of being lost.
   assign redir_hit = bus.redir_valid && (bus.redir_type != 2'b11);

`ifdef FETCH_SEQ_EXC_EN
   assign exc_hit  = bus.exc_req;
   assign eret_hit = bus.eret_req;
   assign eret_tgt = {bus.epc[31:2], 2'b00};
`else
   assign exc_hit  = 1'b0;
   assign eret_hit = 1'b0;
   assign eret_tgt = 32'h0;
`endif

   always_comb begin
      raw_tgt = 32'h0;
      case (bus.redir_type)
         2'b00:   raw_tgt = bus.pc_d + 32'd4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
         2'b01:   raw_tgt = {bus.pc_d[31:28], bus.idx26, 2'b00};
         2'b10:   raw_tgt = bus.rs_val;
         default: raw_tgt = 32'h0;
      endcase
   end

   assign tgt = {raw_tgt[31:2], 2'b00};

   always_comb begin
      en  = 1'b1;
      npc = bus.pc_f + 32'd4;
      if (reset) begin
         npc = RESET_PC;
      end else if (exc_hit) begin
         npc = EXC_PC;
      end else if (eret_hit) begin
         npc = eret_tgt;
      end else if (bus.stall) begin
         en  = 1'b0;
         npc = bus.pc_f;
      end else if (redir_hit) begin
         npc = tgt;
      end else if (state == HOLD) begin
         npc = pend_tgt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         pend_tgt    <= 32'h0;
         misalign_q  <= 1'b0;
         fetch_cnt_q <= 32'h0;
      end else begin
         if (en) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         misalign_q <= 1'b0;
         if (exc_hit || eret_hit) begin
            state    <= RUN;
            pend_tgt <= 32'h0;
         end else if (bus.stall) begin
            // A newer stalled redirect overwrites an older pending one.
            if (redir_hit) begin
               state      <= HOLD;
               pend_tgt   <= tgt;
               misalign_q <= |raw_tgt[1:0];
            end
         end else begin
            state      <= RUN;
            pend_tgt   <= 32'h0;
            misalign_q <= redir_hit && (|raw_tgt[1:0]);
         end
      end
   end

   assign bus.next_pc    = npc;
   assign bus.pc_en      = en;
   assign bus.pend_valid = (state == HOLD);
   assign bus.misalign   = misalign_q;
   assign bus.fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios, then randomized cycles checked
// against a behavioural model of the sequencer (pending target, counter, misalign).
module tb_fetch_sequencer;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC   = 32'h0000_4180;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   // behavioural model state
   logic        m_pend = 1'b0;
   logic [31:0] m_tgt  = 32'h0;
   logic        m_mis  = 1'b0;
   logic [31:0] m_cnt  = 32'h0;

   fetch_sequencer_if bus();

   fetch_sequencer #(.RESET_PC(RESET_PC), .EXC_PC(EXC_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] raw_target(input logic [1:0] t, input logic [31:0] pcd,
                                              input logic [15:0] imm, input logic [25:0] idx,
                                              input logic [31:0] rs);
      logic signed [31:0] off;
      off = 32'($signed(imm));
      case (t)
         2'd0:    return pcd + 32'd4 + 32'(off * 4);
         2'd1:    return (pcd & 32'hF000_0000) | (32'(idx) * 32'd4);
         2'd2:    return rs;
         default: return 32'h0;
      endcase
   endfunction

   // One clock: predict, check at negedge, advance model at posedge, then move the IFU PC.
   task automatic cycle();
      logic [31:0] raw, e_npc, e_epc;
      logic        e_en, hit, exc, eret;
      exc   = 1'b0;
      eret  = 1'b0;
      e_epc = 32'h0;
`ifdef FETCH_SEQ_EXC_EN
      exc   = bus.exc_req;
      eret  = bus.eret_req;
      e_epc = bus.epc & ~32'd3;
`endif
      hit = bus.redir_valid && (bus.redir_type != 2'b11);
      raw = raw_target(bus.redir_type, bus.pc_d, bus.imm16, bus.idx26, bus.rs_val);
      e_en = 1'b1;
      if (reset)           e_npc = RESET_PC;
      else if (exc)        e_npc = EXC_PC;
      else if (eret)       e_npc = e_epc;
      else if (bus.stall) begin e_en = 1'b0; e_npc = bus.pc_f; end
      else if (hit)        e_npc = raw & ~32'd3;
      else if (m_pend)     e_npc = m_tgt;
      else                 e_npc = bus.pc_f + 32'd4;

      @(negedge clk);
      chk("next_pc",    bus.next_pc, e_npc);
      chk("pc_en",      {31'b0, bus.pc_en}, {31'b0, e_en});
      chk("pend_valid", {31'b0, bus.pend_valid}, {31'b0, m_pend});
      chk("misalign",   {31'b0, bus.misalign}, {31'b0, m_mis});
      chk("fetch_cnt",  bus.fetch_cnt, m_cnt);

      @(posedge clk);
      if (reset) begin
         m_pend = 1'b0; m_tgt = 32'h0; m_mis = 1'b0; m_cnt = 32'h0;
      end else begin
         if (e_en) m_cnt = m_cnt + 32'd1;
         m_mis = !(exc || eret) && hit && (raw[1:0] != 2'b00);
         if (exc || eret)     m_pend = 1'b0;
         else if (bus.stall) begin
            if (hit) begin m_pend = 1'b1; m_tgt = raw & ~32'd3; end
         end else             m_pend = 1'b0;
      end
      #1;
      bus.pc_f = reset ? RESET_PC : (e_en ? e_npc : bus.pc_f);
   endtask

   initial begin
      reset           = 1'b1;
      bus.pc_f        = RESET_PC;
      bus.pc_d        = 32'h0;
      bus.stall       = 1'b0;
      bus.redir_valid = 1'b0;
      bus.redir_type  = 2'b00;
      bus.imm16       = 16'h0;
      bus.idx26       = 26'h0;
      bus.rs_val      = 32'h0;
`ifdef FETCH_SEQ_EXC_EN
      bus.exc_req     = 1'b0;
      bus.eret_req    = 1'b0;
      bus.epc         = 32'h0;
`endif
      @(posedge clk);
      #1;

      // reset, then four idle fetches
      #1 chk("rst_npc", bus.next_pc, 32'h0000_3000);
      cycle();
      reset = 1'b0;
      #1 chk("idle_npc0", bus.next_pc, 32'h0000_3004);
      repeat (4) cycle();
      chk("idle_cnt", bus.fetch_cnt, 32'd4);

      // backward branch, unstalled
      bus.redir_valid = 1'b1; bus.redir_type = 2'b00;
      bus.pc_d = 32'h0000_3008; bus.imm16 = 16'hFFFE;
      #1 chk("br_npc", bus.next_pc, 32'h0000_3004);
      cycle();
      chk("br_pend", {31'b0, bus.pend_valid}, 32'd0);

      // jump under stall is held, applied on release
      bus.stall = 1'b1; bus.redir_type = 2'b01;
      bus.pc_d = 32'h0000_3010; bus.idx26 = 26'h0000C40;
      #1 chk("jst_en", {31'b0, bus.pc_en}, 32'd0);
      cycle();
      chk("jst_pend", {31'b0, bus.pend_valid}, 32'd1);
      bus.redir_valid = 1'b0;
      repeat (2) cycle();
      chk("jst_cnt", bus.fetch_cnt, 32'd5);
      bus.stall = 1'b0;
      #1 chk("jrel_npc", bus.next_pc, 32'h0000_3100);
      cycle();
      chk("jrel_pend", {31'b0, bus.pend_valid}, 32'd0);

      // misaligned jr
      bus.redir_valid = 1'b1; bus.redir_type = 2'b10; bus.rs_val = 32'h0000_3021;
      #1 chk("jr_npc", bus.next_pc, 32'h0000_3020);
      cycle();
      chk("jr_mis1", {31'b0, bus.misalign}, 32'd1);
      bus.redir_valid = 1'b0;
      cycle();
      chk("jr_mis0", {31'b0, bus.misalign}, 32'd0);

      // reset while holding drops the pending target
      bus.stall = 1'b1; bus.redir_valid = 1'b1; bus.redir_type = 2'b01;
      bus.pc_d = 32'h0000_3010; bus.idx26 = 26'h0000C40;
      cycle();
      chk("hold_pend", {31'b0, bus.pend_valid}, 32'd1);
      reset = 1'b1;
      cycle();
      chk("rsth_pend", {31'b0, bus.pend_valid}, 32'd0);
      chk("rsth_cnt", bus.fetch_cnt, 32'd0);
      reset = 1'b0; bus.stall = 1'b0; bus.redir_valid = 1'b0;
      #1 chk("rsth_npc", bus.next_pc, 32'h0000_3004);
      cycle();

`ifdef FETCH_SEQ_EXC_EN
      // exception beats eret and stall, clears pending
      bus.stall = 1'b1; bus.redir_valid = 1'b1; bus.redir_type = 2'b10;
      bus.rs_val = 32'h0000_5000;
      cycle();
      bus.redir_valid = 1'b0; bus.exc_req = 1'b1; bus.eret_req = 1'b1;
      bus.epc = 32'h0000_6003;
      #1 chk("exc_npc", bus.next_pc, 32'h0000_4180);
      chk("exc_en", {31'b0, bus.pc_en}, 32'd1);
      cycle();
      chk("exc_pend", {31'b0, bus.pend_valid}, 32'd0);
      bus.exc_req = 1'b0;
      #1 chk("eret_npc", bus.next_pc, 32'h0000_6000);
      cycle();
      bus.eret_req = 1'b0; bus.stall = 1'b0;
`endif

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         reset           = ($urandom_range(0, 49) == 0);
         bus.stall       = ($urandom_range(0, 99) < 40);
         bus.redir_valid = 1'($urandom_range(0, 1));
         bus.redir_type  = 2'($urandom_range(0, 3));
         bus.pc_d        = $urandom;
         bus.imm16       = 16'($urandom);
         bus.idx26       = 26'($urandom);
         bus.rs_val      = $urandom;
`ifdef FETCH_SEQ_EXC_EN
         bus.exc_req     = ($urandom_range(0, 19) == 0);
         bus.eret_req    = ($urandom_range(0, 19) == 0);
         bus.epc         = $urandom;
`endif
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction-fetch PC register (IFU). Each cycle it generates the IFU's nextPC and En inputs.
- Decodes redirects (branch, j/jal, jr/jalr) resolved in the D stage and computes their targets.
- A redirect that arrives while the pipeline is stalled is held in a one-entry pending latch and applied when the stall releases.
- Also keeps a retired-fetch counter for performance monitoring.

Parameters:
- RESET_PC, 32'h00003000, value the sequencer treats as the PC after reset. Must match the IFU reset value.
- EXC_PC, 32'h00004180, exception handler entry. Used only with EXC_EN.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- pc_f  input  32  current fetch PC from the IFU
- pc_d  input  32  PC of the instruction in the D stage
- stall  input  1  pipeline freeze request from the hazard unit
- redir_valid  input  1  D-stage redirect is taken this cycle
- redir_type  input  2  00 branch, 01 j/jal, 10 jr/jalr, 11 reserved (treated as no redirect)
- imm16  input  16  branch offset field
- idx26  input  26  jump index field
- rs_val  input  32  forwarded register value for jr/jalr
- next_pc  output  32  to the IFU nextPC input
- pc_en  output  1  to the IFU En input
- pend_valid  output  1  a redirect is latched and waiting
- misalign  output  1  registered one-cycle pulse: the applied target had bits[1:0] != 0
- fetch_cnt  output  32  number of cycles in which pc_en=1 since reset

Behaviour:
- Target computation (combinational, 32-bit, overflow wraps):
  - branch: pc_d + 4 + (sign-extended imm16 << 2)
  - jump: {pc_d[31:28], idx26, 2'b00}
  - jr: rs_val
  - Applied target always has bits[1:0] forced to 00.
- State: RUN (pend_valid=0) or HOLD (pend_valid=1). pend_tgt register is 32 bits.
- Combinational outputs, in priority order:
  - stall=1: pc_en=0, next_pc=pc_f.
  - stall=0 and a valid redirect (redir_valid=1 and type != 11): pc_en=1, next_pc=computed target. This also applies in HOLD; the new redirect beats pend_tgt.
  - stall=0 and HOLD: pc_en=1, next_pc=pend_tgt.
  - Otherwise: pc_en=1, next_pc=pc_f+4.
- Register updates at posedge clk:
  - RUN, stall=1, valid redirect: capture target into pend_tgt, go to HOLD.
  - HOLD, stall=1, valid redirect: overwrite pend_tgt, stay in HOLD.
  - Any state, stall=0: go to RUN and clear pending.
- misalign is registered. It is 1 in the cycle after any cycle in which a target was applied to next_pc (or captured into pend_tgt) and its raw bits[1:0] were nonzero. Otherwise 0.
- fetch_cnt increments by 1 on each posedge with pc_en=1 and reset=0. It wraps from 32'hFFFFFFFF to 0.
- Reset (synchronous):
  - pend_valid=0, pend_tgt=0, misalign=0, fetch_cnt=0.
  - While reset=1: pc_en=1, next_pc=RESET_PC.
  - Reset asserted during HOLD drops the pending target.
- Latency:
  - A redirect with stall=0 is visible in pc_f one cycle later.
  - A stalled redirect is applied in the first cycle with stall=0 and reaches pc_f one cycle after that.

Optional Feature:
- Macro: FETCH_SEQ_EXC_EN.
- Defined: adds inputs exc_req (1), eret_req (1), epc (32).
  - exc_req has the highest priority after reset and overrides stall: pc_en=1, next_pc=EXC_PC, pending cleared.
  - eret_req is next in priority, also overrides stall: pc_en=1, next_pc={epc[31:2],2'b00}, pending cleared.
  - Both requests in the same cycle: exc_req wins.
- Undefined: these ports and that logic do not exist. Behaviour is exactly as in Behaviour.

Test Plan:
- Reset, then 4 idle cycles -> next_pc=0x3000 during reset; pc_f steps 0x3000, 0x3004, 0x3008, 0x300C; fetch_cnt=4.
- redir_valid=1, type=00, pc_d=0x3008, imm16=16'hFFFE, stall=0 -> next_pc=0x3004 same cycle, pend_valid stays 0.
- stall=1 with type=01, pc_d=0x3010, idx26=0x0000C40 -> pc_en=0, pend_valid=1 next cycle. Hold stall 3 cycles, then stall=0 with redir_valid=0 -> next_pc=0x00003100, pend_valid=0 after that edge, fetch_cnt unchanged during the stall.
- jr with rs_val=0x00003021, stall=0 -> next_pc=0x00003020, misalign=1 for exactly one cycle.
- HOLD with pend_tgt=0x3100, then reset=1 for 1 cycle -> pend_valid=0, fetch_cnt=0, next PC=0x3000 (no 0x3100 fetch).
- With FETCH_SEQ_EXC_EN: stall=1, exc_req=1 and eret_req=1 in the same cycle -> pc_en=1, next_pc=0x4180, pending cleared.
